jtag_mem_arbiter: RTL and testbench

//  Shares one single-port, 1-cycle-read-latency memory between the CPU data port and the JTAG debug

---
 rtl/jtag_mem_arbiter.sv | 103 ++++++++++
 tb/tb_jtag_mem_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_mem_arbiter.sv
// jtag_mem_arbiter: shares one 1-cycle-latency single-port memory between the CPU data port and the JTAG debug bridge
module jtag_mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          DBG_REQ,
    input  logic          DBG_WE,
    input  logic [AW-1:0] DBG_ADDR,
    input  logic [DW-1:0] DBG_WDATA,
    input  logic          DBG_ERR_CLR,
    output logic          DBG_BUSY,
    output logic          DBG_RVALID,
    output logic [DW-1:0] DBG_RDATA,
    output logic          DBG_OVERRUN,
    input  logic          CPU_REQ,
    input  logic          CPU_WE,
    input  logic [AW-1:0] CPU_ADDR,
    input  logic [DW-1:0] CPU_WDATA,
    output logic          CPU_GNT,
    output logic          CPU_RVALID,
    output logic [DW-1:0] CPU_RDATA,
    output logic          MEM_EN,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    input  logic [DW-1:0] MEM_RDATA
);
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG} owner_t;

    logic          pend_q, pend_d;
    logic          hold_we_q, hold_we_d;
    logic [AW-1:0] hold_addr_q, hold_addr_d;
    logic [DW-1:0] hold_wdata_q, hold_wdata_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          ovr_q, ovr_d;
    logic          dbg_rvalid_q, dbg_rvalid_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
    owner_t        owner_q, owner_d;
    logic          dbg_win, cpu_win, cap;

    assign DBG_BUSY    = pend_q;
    assign DBG_RVALID  = dbg_rvalid_q;
    assign DBG_RDATA   = dbg_rdata_q;
    assign DBG_OVERRUN = ovr_q;

    // Arbitration and memory-port mux; the CPU path is gated by RSTN so every output is 0 in reset
    always_comb begin
        dbg_win    = pend_q & (~CPU_REQ | (starve_q == STARVE_LIM));
        cpu_win    = RSTN & CPU_REQ & ~dbg_win;
        MEM_EN     = dbg_win | cpu_win;
        MEM_WE     = dbg_win ? hold_we_q : (cpu_win & CPU_WE);
        MEM_ADDR   = dbg_win ? hold_addr_q : (cpu_win ? CPU_ADDR : '0);
        MEM_WDATA  = dbg_win ? hold_wdata_q : (cpu_win ? CPU_WDATA : '0);
        CPU_GNT    = cpu_win;
        CPU_RVALID = owner_q == OWN_CPU;
        CPU_RDATA  = RSTN ? MEM_RDATA : '0;
    end

    // Next state: debug capture/drop, starvation count, overrun flag and read-return ownership
    always_comb begin
        cap          = DBG_REQ & (~pend_q | dbg_win);
        pend_d       = cap | (pend_q & ~dbg_win);
        hold_we_d    = cap ? DBG_WE : hold_we_q;
        hold_addr_d  = cap ? DBG_ADDR : hold_addr_q;
        hold_wdata_d = cap ? DBG_WDATA : hold_wdata_q;
        starve_d     = (pend_q & ~dbg_win) ? starve_q + 1'b1 : '0;
        ovr_d        = (DBG_REQ & ~cap) | (ovr_q & ~DBG_ERR_CLR);
        owner_d      = (dbg_win & ~hold_we_q) ? OWN_DBG : ((cpu_win & ~CPU_WE) ? OWN_CPU : OWN_NONE);
        dbg_rvalid_d = owner_q == OWN_DBG;
        dbg_rdata_d  = dbg_rvalid_d ? MEM_RDATA : dbg_rdata_q;
    end

    // State registers; reset drops any pending request and any in-flight read return
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pend_q       <= 1'b0;
            hold_we_q    <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            starve_q     <= '0;
            ovr_q        <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
            owner_q      <= OWN_NONE;
        end else begin
            pend_q       <= pend_d;
            hold_we_q    <= hold_we_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            starve_q     <= starve_d;
            ovr_q        <= ovr_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_rdata_q  <= dbg_rdata_d;
            owner_q      <= owner_d;
        end
    end
endmodule

// File: tb/tb_jtag_mem_arbiter.sv
// tb_jtag_mem_arbiter: vector table, directed multi-cycle corner cases and a randomized run against a reference model
module tb_jtag_mem_arbiter;
    localparam int SMAX = 8;
    localparam logic H = 1'b1, L = 1'b0;
    localparam logic [31:0] Z = 32'h0, D = 32'h12345678;

    logic CLK = 1'b0, RSTN = 1'b0;
    logic DBG_REQ, DBG_WE, DBG_ERR_CLR, CPU_REQ, CPU_WE;
    logic [31:0] DBG_ADDR, DBG_WDATA, CPU_ADDR, CPU_WDATA, MEM_RDATA;
    logic DBG_BUSY, DBG_RVALID, DBG_OVERRUN, CPU_GNT, CPU_RVALID, MEM_EN, MEM_WE;
    logic [31:0] DBG_RDATA, CPU_RDATA, MEM_ADDR, MEM_WDATA;
    logic [134:0] obs;
    int checks = 0, errors = 0;

    typedef struct {
        logic dreq, dwe; logic [31:0] daddr, dwd;
        logic creq, cwe; logic [31:0] caddr, cwd, mrd;
        logic [134:0] exp;
    } vec_t;
    typedef struct { logic we; logic [31:0] addr, wd; } req_t;
    typedef struct { bit dbg; int due; } rd_t;

    vec_t vecs[$];
    req_t dq[$], hd;
    rd_t rq[$];
    int losses, cyc;
    bit m_ovr, m_drv, p, dw, cw, crv, last_gnt, drop;
    logic [31:0] m_drd;

    jtag_mem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(SMAX)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .DBG_REQ(DBG_REQ), .DBG_WE(DBG_WE), .DBG_ADDR(DBG_ADDR), .DBG_WDATA(DBG_WDATA),
        .DBG_ERR_CLR(DBG_ERR_CLR), .DBG_BUSY(DBG_BUSY), .DBG_RVALID(DBG_RVALID),
        .DBG_RDATA(DBG_RDATA), .DBG_OVERRUN(DBG_OVERRUN),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
        .CPU_GNT(CPU_GNT), .CPU_RVALID(CPU_RVALID), .CPU_RDATA(CPU_RDATA),
        .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA)
    );

    always #5 CLK = ~CLK;

    assign obs = {MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, DBG_BUSY, CPU_GNT, DBG_RVALID,
                  DBG_RDATA, DBG_OVERRUN, CPU_RVALID, CPU_RDATA};

    function automatic vec_t mk(logic dreq, dwe, logic [31:0] daddr, dwd, logic creq, cwe,
                                logic [31:0] caddr, cwd, mrd, logic en, we, logic [31:0] addr, wd,
                                logic busy, gnt, drv, logic [31:0] drd, logic ovr, crvl);
        mk = '{dreq, dwe, daddr, dwd, creq, cwe, caddr, cwd, mrd,
               {en, we, addr, wd, busy, gnt, drv, drd, ovr, crvl, mrd}};
    endfunction

    task automatic check(input string nm, input logic [134:0] got, input logic [134:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic idle();
        {DBG_REQ, DBG_WE, DBG_ERR_CLR, CPU_REQ, CPU_WE} = '0;
        {DBG_ADDR, DBG_WDATA, CPU_ADDR, CPU_WDATA, MEM_RDATA} = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        idle();
        RSTN = 1'b0;
        tick();
        RSTN = 1'b1;
    endtask

    task automatic mreset();
        dq.delete();
        rq.delete();
        losses = 0;
        m_ovr = 0;
        m_drv = 0;
        m_drd = '0;
    endtask

    initial begin
        idle();
        CPU_REQ = 1'b1;
        MEM_RDATA = 32'hFFFF_FFFF;
        @(negedge CLK);
        check("reset_outputs", obs, '0);
        tick();
        RSTN = 1'b1;
        idle();

        vecs.push_back(mk(H,H,32'h100,32'hDEADBEEF, L,L,Z,Z,Z, L,L,Z,Z,L,L,L,Z,L,L));
        vecs.push_back(mk(L,L,Z,Z, L,L,Z,Z,Z, H,H,32'h100,32'hDEADBEEF,H,L,L,Z,L,L));
        vecs.push_back(mk(L,L,Z,Z, L,L,Z,Z,Z, L,L,Z,Z,L,L,L,Z,L,L));
        vecs.push_back(mk(H,L,32'h40,Z, L,L,Z,Z,Z, L,L,Z,Z,L,L,L,Z,L,L));
        vecs.push_back(mk(L,L,Z,Z, L,L,Z,Z,Z, H,L,32'h40,Z,H,L,L,Z,L,L));
        vecs.push_back(mk(L,L,Z,Z, L,L,Z,Z,D, L,L,Z,Z,L,L,L,Z,L,L));
        vecs.push_back(mk(L,L,Z,Z, L,L,Z,Z,32'hAAAAAAAA, L,L,Z,Z,L,L,H,D,L,L));
        vecs.push_back(mk(L,L,Z,Z, L,L,Z,Z,32'h55555555, L,L,Z,Z,L,L,L,D,L,L));
        vecs.push_back(mk(H,H,32'h200,32'h11111111, L,L,Z,Z,Z, L,L,Z,Z,L,L,L,D,L,L));
        vecs.push_back(mk(H,H,32'h204,32'h22222222, L,L,Z,Z,Z, H,H,32'h200,32'h11111111,H,L,L,D,L,L));
        vecs.push_back(mk(L,L,Z,Z, L,L,Z,Z,Z, H,H,32'h204,32'h22222222,H,L,L,D,L,L));
        vecs.push_back(mk(L,L,Z,Z, L,L,Z,Z,Z, L,L,Z,Z,L,L,L,D,L,L));
        vecs.push_back(mk(L,L,Z,Z, H,L,32'h300,Z,Z, H,L,32'h300,Z,L,H,L,D,L,L));
        vecs.push_back(mk(L,L,Z,Z, L,L,Z,Z,32'hCAFEF00D, L,L,Z,Z,L,L,L,D,L,H));
        vecs.push_back(mk(L,L,Z,Z, H,H,32'h304,32'h0BADC0DE,Z, H,H,32'h304,32'h0BADC0DE,L,H,L,D,L,L));
        vecs.push_back(mk(L,L,Z,Z, L,L,Z,Z,Z, L,L,Z,Z,L,L,L,D,L,L));
        vecs.push_back(mk(H,L,32'h80,Z, H,L,32'h308,Z,Z, H,L,32'h308,Z,L,H,L,D,L,L));
        vecs.push_back(mk(L,L,Z,Z, L,L,Z,Z,32'h77777777, H,L,32'h80,Z,H,L,L,D,L,H));
        vecs.push_back(mk(L,L,Z,Z, L,L,Z,Z,32'h88888888, L,L,Z,Z,L,L,L,D,L,L));
        vecs.push_back(mk(L,L,Z,Z, L,L,Z,Z,32'h99999999, L,L,Z,Z,L,L,H,32'h88888888,L,L));
        vecs.push_back(mk(L,L,Z,Z, L,L,Z,Z,Z, L,L,Z,Z,L,L,L,32'h88888888,L,L));

        foreach (vecs[i]) begin
            {DBG_REQ, DBG_WE, DBG_ADDR, DBG_WDATA} = {vecs[i].dreq, vecs[i].dwe, vecs[i].daddr, vecs[i].dwd};
            {CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA} = {vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd};
            MEM_RDATA = vecs[i].mrd;
            @(negedge CLK);
            check($sformatf("vec%0d", i), obs, vecs[i].exp);
            tick();
        end

        // starvation: CPU holds the port, debug gets exactly one slot after 8 losses
        do_reset();
        {CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA} = {1'b1, 1'b1, 32'hA0, 32'h1};
        for (int c = 0; c <= 12; c++) begin
            {DBG_REQ, DBG_WE, DBG_ADDR, DBG_WDATA} = {c == 0, 1'b1, 32'hB0, 32'h5};
            @(negedge CLK);
            check($sformatf("starve_c%0d", c), {CPU_GNT, MEM_EN, MEM_ADDR},
                  {c != 9, 1'b1, (c == 9) ? 32'hB0 : 32'hA0});
            tick();
        end

        // overrun: dropped strobe keeps first request, clear, then set-beats-clear
        do_reset();
        {CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA} = {1'b1, 1'b1, 32'hA0, 32'h1};
        for (int c = 0; c <= 13; c++) begin
            DBG_REQ = (c == 0) || (c == 2) || (c == 11) || (c == 12);
            DBG_WE = 1'b1;
            DBG_ADDR = (c == 0) ? 32'h10 : ((c == 2) ? 32'h20 : 32'h30);
            DBG_ERR_CLR = (c == 10) || (c == 12);
            @(negedge CLK);
            check($sformatf("ovr_flag_c%0d", c), DBG_OVERRUN, ((c >= 3) && (c <= 10)) || (c == 13));
            check($sformatf("ovr_port_c%0d", c), {CPU_GNT, MEM_ADDR}, (c == 9) ? {1'b0, 32'h10} : {1'b1, 32'hA0});
            tick();
        end

        // reset in the middle of a CPU read with a debug request pending
        do_reset();
        {DBG_REQ, DBG_WE, DBG_ADDR} = {1'b1, 1'b1, 32'h44};
        tick();
        DBG_REQ = 1'b0;
        {CPU_REQ, CPU_WE, CPU_ADDR} = {1'b1, 1'b0, 32'h300};
        MEM_RDATA = 32'hFFFF0000;
        @(negedge CLK);
        check("rst_pre", {CPU_GNT, DBG_BUSY, MEM_EN}, 3'b111);
        #1 RSTN = 1'b0;
        #1 check("rst_mid", obs, '0);
        tick();
        @(negedge CLK);
        check("rst_hold", obs, '0);
        tick();
        RSTN = 1'b1;
        CPU_REQ = 1'b0;
        MEM_RDATA = '0;
        @(negedge CLK);
        check("rst_after", obs, '0);
        tick();

        // randomized run against the reference model
        do_reset();
        mreset();
        last_gnt = 0;
        cyc = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!(CPU_REQ && !last_gnt)) begin
                CPU_REQ = $urandom_range(0, 99) < 60;
                CPU_WE = 1'($urandom());
                CPU_ADDR = $urandom();
                CPU_WDATA = $urandom();
            end
            DBG_REQ = $urandom_range(0, 99) < 30;
            DBG_WE = 1'($urandom());
            DBG_ADDR = $urandom();
            DBG_WDATA = $urandom();
            DBG_ERR_CLR = $urandom_range(0, 99) < 5;
            MEM_RDATA = $urandom();
            if ($urandom_range(0, 499) == 0) begin
                RSTN = 1'b0;
                @(negedge CLK);
                check("rand_reset", obs, '0);
                mreset();
                last_gnt = 0;
                tick();
                RSTN = 1'b1;
                continue;
            end
            @(negedge CLK);
            p = dq.size() != 0;
            if (p) hd = dq[0];
            dw = p && (!CPU_REQ || losses == SMAX);
            cw = CPU_REQ && !dw;
            crv = rq.size() != 0 && rq[0].due == cyc && !rq[0].dbg;
            check($sformatf("rand_c%0d", n), obs,
                  {dw | cw, dw ? hd.we : (cw & CPU_WE), dw ? hd.addr : (cw ? CPU_ADDR : 32'h0),
                   dw ? hd.wd : (cw ? CPU_WDATA : 32'h0), p, cw, m_drv, m_drd, m_ovr, crv, MEM_RDATA});
            m_drv = 0;
            if (rq.size() != 0 && rq[0].due == cyc) begin
                if (rq[0].dbg) begin
                    m_drv = 1;
                    m_drd = MEM_RDATA;
                end
                void'(rq.pop_front());
            end
            if (dw && !hd.we) rq.push_back('{1'b1, cyc + 1});
            if (cw && !CPU_WE) rq.push_back('{1'b0, cyc + 1});
            if (dw) begin
                void'(dq.pop_front());
                losses = 0;
            end else losses = p ? losses + 1 : 0;
            drop = DBG_REQ && dq.size() != 0;
            if (DBG_REQ && !drop) dq.push_back('{DBG_WE, DBG_ADDR, DBG_WDATA});
            if (drop) m_ovr = 1;
            else if (DBG_ERR_CLR) m_ovr = 0;
            last_gnt = cw;
            cyc++;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
